// File: rtl/mod_fetch_buffer_pkg.sv
// Shared types and constants for the instruction fetch buffer.
package mod_fetch_buffer_pkg;

    localparam int unsigned FETCH_WORD_BYTES = 8;

    typedef enum logic [1:0] {
        FB_REQ,
        FB_WAIT,
        FB_DROP,
        FB_STALL
    } fb_state_t;

    // Single-step modulo reduction; callers keep idx below 2*size.
    function automatic int unsigned ring_wrap(input int unsigned idx, input int unsigned size);
        return (idx >= size) ? idx - size : idx;
    endfunction

endpackage

// File: rtl/fb_byte_ring.sv
// Circular byte store: 8-byte appends at the tail, WIN_BYTES-wide window read at the head.
module fb_byte_ring
    import mod_fetch_buffer_pkg::*;
#(
    parameter int unsigned BUF_BYTES = 32,
    parameter int unsigned WIN_BYTES = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   flush,
    input  logic                   wr_en,
    input  logic [2:0]             wr_skip,
    input  logic [63:0]            wr_data,
    input  logic [4:0]             rd_pop,
    output logic [8*WIN_BYTES-1:0] rd_bytes
);

    localparam int unsigned PW = $clog2(BUF_BYTES);

    logic [7:0]    mem [BUF_BYTES];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] head_nxt;
    logic [PW-1:0] tail_nxt;

    assign head_nxt = PW'(ring_wrap(32'(head) + 32'(rd_pop), BUF_BYTES));
    assign tail_nxt = PW'(ring_wrap(32'(tail) + FETCH_WORD_BYTES - 32'(wr_skip), BUF_BYTES));

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            head <= '0;
            tail <= '0;
        end else begin
            head <= head_nxt;
            if (wr_en) begin
                tail <= tail_nxt;
            end
        end
    end

    // Skipped low bytes are simply not written; the tail advances by the kept count.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int unsigned i = 0; i < FETCH_WORD_BYTES; i++) begin
                if (i >= 32'(wr_skip)) begin
                    mem[PW'(ring_wrap(32'(tail) + i - 32'(wr_skip), BUF_BYTES))] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        rd_bytes = '0;
        for (int unsigned i = 0; i < WIN_BYTES; i++) begin
            rd_bytes[8*i +: 8] = mem[PW'(ring_wrap(32'(head) + i, BUF_BYTES))];
        end
    end

endmodule

// File: rtl/mod_fetch_buffer.sv
// Fetch buffer: issues 8-byte icache requests, queues returned bytes and
// presents the oldest bytes to decode, with redirect and stale-response handling.
module mod_fetch_buffer
    import mod_fetch_buffer_pkg::*;
#(
    parameter int unsigned BUF_BYTES = 32,
    parameter int unsigned WIN_BYTES = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [63:0]                  entry,
    input  logic                         redirect,
    input  logic [63:0]                  redirect_pc,
    output logic                         ic_req_valid,
    output logic [63:0]                  ic_req_addr,
    input  logic                         ic_req_ready,
    input  logic                         ic_resp_valid,
    input  logic [63:0]                  ic_resp_data,
    output logic [8*WIN_BYTES-1:0]       fb_bytes,
    output logic [$clog2(BUF_BYTES):0]   fb_count,
    output logic [63:0]                  fb_pc,
    input  logic [4:0]                   consume
);

    localparam int unsigned CW = $clog2(BUF_BYTES) + 1;

    fb_state_t     state;
    fb_state_t     state_nxt;
    logic [2:0]    start_off;
    logic          first_resp;
    logic          handshake;
    logic          resp_take;
    logic          room_ok;
    logic [CW-1:0] append_n;
    logic [CW-1:0] count_after;

    assign handshake   = ic_req_valid && ic_req_ready;
    assign resp_take   = (state == FB_WAIT) && ic_resp_valid && !redirect;
    assign append_n    = first_resp ? CW'(FETCH_WORD_BYTES) - CW'(start_off) : CW'(FETCH_WORD_BYTES);
    assign count_after = fb_count - CW'(consume) + (resp_take ? append_n : '0);
    assign room_ok     = (CW'(BUF_BYTES) - count_after) >= CW'(FETCH_WORD_BYTES);

    // A redirect orphans any request in flight; DROP waits out its response.
    always_comb begin
        state_nxt = state;
        if (redirect) begin
            case (state)
                FB_REQ:           state_nxt = handshake ? FB_DROP : FB_REQ;
                FB_WAIT, FB_DROP: state_nxt = ic_resp_valid ? FB_REQ : FB_DROP;
                FB_STALL:         state_nxt = FB_REQ;
            endcase
        end else begin
            case (state)
                FB_REQ:   if (handshake) state_nxt = FB_WAIT;
                FB_WAIT:  if (ic_resp_valid) state_nxt = room_ok ? FB_REQ : FB_STALL;
                FB_DROP:  if (ic_resp_valid) state_nxt = FB_REQ;
                FB_STALL: if (room_ok) state_nxt = FB_REQ;
            endcase
        end
    end

    // ic_req_addr doubles as the fetch address register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= FB_REQ;
            ic_req_valid <= 1'b0;
            ic_req_addr  <= {entry[63:3], 3'b000};
            start_off    <= entry[2:0];
            first_resp   <= 1'b1;
            fb_count     <= '0;
            fb_pc        <= entry;
        end else begin
            state        <= state_nxt;
            ic_req_valid <= (state_nxt == FB_REQ);
            if (redirect) begin
                ic_req_addr <= {redirect_pc[63:3], 3'b000};
                start_off   <= redirect_pc[2:0];
                first_resp  <= 1'b1;
                fb_count    <= '0;
                fb_pc       <= redirect_pc;
            end else begin
                fb_count <= count_after;
                fb_pc    <= fb_pc + 64'(consume);
                if (resp_take) begin
                    ic_req_addr <= ic_req_addr + 64'(FETCH_WORD_BYTES);
                    first_resp  <= 1'b0;
                end
            end
        end
    end

    fb_byte_ring #(
        .BUF_BYTES (BUF_BYTES),
        .WIN_BYTES (WIN_BYTES)
    ) u_ring (
        .clk      (clk),
        .reset    (reset),
        .flush    (redirect),
        .wr_en    (resp_take),
        .wr_skip  (first_resp ? start_off : 3'd0),
        .wr_data  (ic_resp_data),
        .rd_pop   (consume),
        .rd_bytes (fb_bytes)
    );

    consume_in_range: assert property (@(posedge clk) disable iff (reset) CW'(consume) <= fb_count);

endmodule

// File: tb/tb_mod_fetch_buffer.sv
// Self-checking bench for mod_fetch_buffer against a byte-queue reference model.
module tb_mod_fetch_buffer;
    import mod_fetch_buffer_pkg::*;

    localparam int unsigned BUF_BYTES = 32;
    localparam int unsigned WIN_BYTES = 16;
    localparam int unsigned CW        = $clog2(BUF_BYTES) + 1;

    logic                   clk;
    logic                   reset;
    logic [63:0]            entry;
    logic                   redirect;
    logic [63:0]            redirect_pc;
    logic                   ic_req_valid;
    logic [63:0]            ic_req_addr;
    logic                   ic_req_ready;
    logic                   ic_resp_valid;
    logic [63:0]            ic_resp_data;
    logic [8*WIN_BYTES-1:0] fb_bytes;
    logic [CW-1:0]          fb_count;
    logic [63:0]            fb_pc;
    logic [4:0]             consume;

    mod_fetch_buffer #(.BUF_BYTES(BUF_BYTES), .WIN_BYTES(WIN_BYTES)) dut (
        .clk(clk), .reset(reset), .entry(entry), .redirect(redirect), .redirect_pc(redirect_pc),
        .ic_req_valid(ic_req_valid), .ic_req_addr(ic_req_addr), .ic_req_ready(ic_req_ready),
        .ic_resp_valid(ic_resp_valid), .ic_resp_data(ic_resp_data),
        .fb_bytes(fb_bytes), .fb_count(fb_count), .fb_pc(fb_pc), .consume(consume)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // icache responder state and knobs
    bit          ic_pend   = 1'b0;
    int          ic_delay  = 0;
    logic [63:0] ic_addr   = '0;
    int          lat_min   = 1;
    int          lat_max   = 1;
    int          ready_pct = 100;
    bit          last_hs   = 1'b0;

    // reference model: architectural byte queue plus fetch bookkeeping
    logic [7:0]  m_q[$];
    logic [63:0] m_pc    = '0;
    logic [63:0] m_fetch = '0;
    logic [2:0]  m_skip  = '0;
    bit          m_first = 1'b1;
    bit          m_out   = 1'b0;
    bit          m_valid = 1'b0;
    int          m_gen   = 0;
    int          m_req_gen = 0;

    function automatic logic [7:0] mem_byte(input logic [63:0] a);
        return (a[7:0] * 8'd3) ^ a[15:8] ^ a[23:16] ^ 8'hA5;
    endfunction

    function automatic logic [63:0] mem_word(input logic [63:0] a);
        logic [63:0] w;
        for (int i = 0; i < 8; i++) w[8*i +: 8] = mem_byte(a + 64'(i));
        return w;
    endfunction

    function automatic logic [8*WIN_BYTES-1:0] win_mask();
        logic [8*WIN_BYTES-1:0] m = '0;
        for (int i = 0; i < int'(WIN_BYTES); i++) if (i < m_q.size()) m[8*i +: 8] = 8'hFF;
        return m;
    endfunction

    function automatic logic [8*WIN_BYTES-1:0] win_exp();
        logic [8*WIN_BYTES-1:0] e = '0;
        for (int i = 0; i < int'(WIN_BYTES); i++) if (i < m_q.size()) e[8*i +: 8] = m_q[i];
        return e;
    endfunction

    // One clock: drive inputs in the low phase, advance the model, cross the edge.
    task automatic run_cycle(input int cons, input bit redir, input logic [63:0] rpc, input bit rst);
        bit          resp;
        bit          hs;
        int          old_gen;
        logic [63:0] req_addr;
        resp          = ic_pend && (ic_delay == 0) && !rst;
        ic_resp_valid = resp;
        ic_resp_data  = resp ? mem_word(ic_addr) : {$urandom, $urandom};
        ic_req_ready  = (int'($urandom_range(99, 0)) < ready_pct);
        consume       = 5'(cons);
        redirect      = redir;
        redirect_pc   = rpc;
        reset         = rst;
        hs            = ic_req_valid && ic_req_ready && !rst;
        req_addr      = ic_req_addr;
        old_gen       = m_gen;
        if (rst) begin
            m_q.delete();
            m_pc = entry; m_fetch = {entry[63:3], 3'b000}; m_skip = entry[2:0];
            m_first = 1'b1; m_out = 1'b0; m_gen++;
        end else begin
            if (redir) begin
                m_q.delete();
                m_pc = rpc; m_fetch = {rpc[63:3], 3'b000}; m_skip = rpc[2:0];
                m_first = 1'b1; m_gen++;
            end else begin
                for (int i = 0; i < cons; i++) void'(m_q.pop_front());
                m_pc += 64'(cons);
                if (resp && m_req_gen == m_gen) begin
                    for (int i = (m_first ? int'(m_skip) : 0); i < 8; i++)
                        m_q.push_back(mem_byte(m_fetch + 64'(i)));
                    m_fetch += 64'd8;
                    m_first = 1'b0;
                end
            end
            if (hs) begin
                m_out = 1'b1; m_req_gen = old_gen;
            end else if (resp) begin
                m_out = 1'b0;
            end
        end
        m_valid = !rst && !m_out && ((int'(BUF_BYTES) - m_q.size()) >= 8);
        last_hs = hs;
        @(posedge clk);
        if (rst) begin
            ic_pend = 1'b0;
        end else begin
            if (resp) ic_pend = 1'b0;
            else if (ic_pend) ic_delay--;
            if (hs) begin
                ic_pend  = 1'b1;
                ic_addr  = req_addr;
                ic_delay = int'($urandom_range(lat_max, lat_min)) - 1;
            end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset(input logic [63:0] ent);
        entry = ent;
        run_cycle(0, 1'b0, '0, 1'b1);
        run_cycle(0, 1'b0, '0, 1'b1);
    endtask

    task automatic test_reset();
        lat_min = 1; lat_max = 1; ready_pct = 100;
        do_reset(64'h1000);
        n_checks++; if (fb_count !== '0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", fb_count); end
        n_checks++; if (fb_pc !== 64'h1000) begin n_fail++; $display("FAIL reset_pc: got %h want 1000", fb_pc); end
        n_checks++; if (ic_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", ic_req_valid); end
        run_cycle(0, 1'b0, '0, 1'b0);
        n_checks++; if (ic_req_valid !== 1'b1) begin n_fail++; $display("FAIL first_valid: got %b want 1", ic_req_valid); end
        n_checks++; if (ic_req_addr !== 64'h1000) begin n_fail++; $display("FAIL first_addr: got %h want 1000", ic_req_addr); end
    endtask

    task automatic test_fill_stall();
        int seq[4] = '{8, 16, 24, 32};
        int idx = 0;
        int hs_cnt = 0;
        logic [CW-1:0] prev = '0;
        lat_min = 1; lat_max = 1; ready_pct = 100;
        do_reset(64'h1000);
        for (int k = 0; k < 30; k++) begin
            run_cycle(0, 1'b0, '0, 1'b0);
            if (last_hs) hs_cnt++;
            if (fb_count !== prev) begin
                n_checks++;
                if (idx >= 4 || 32'(fb_count) != 32'(seq[idx])) begin
                    n_fail++; $display("FAIL fill_seq step %0d: got %0d", idx, fb_count);
                end
                prev = fb_count; idx++;
            end
        end
        n_checks++; if (idx != 4) begin n_fail++; $display("FAIL fill_steps: got %0d want 4", idx); end
        n_checks++; if (hs_cnt != 4) begin n_fail++; $display("FAIL fill_requests: got %0d want 4", hs_cnt); end
        n_checks++; if (ic_req_valid !== 1'b0) begin n_fail++; $display("FAIL fill_valid: got %b want 0", ic_req_valid); end
        n_checks++; if (dut.state !== FB_STALL) begin n_fail++; $display("FAIL fill_state: got %0d want %0d", dut.state, FB_STALL); end
    endtask

    task automatic test_unaligned_entry();
        lat_min = 1; lat_max = 1; ready_pct = 100;
        do_reset(64'h1005);
        for (int k = 0; k < 5 && !ic_req_valid; k++) run_cycle(0, 1'b0, '0, 1'b0);
        n_checks++; if (ic_req_addr !== 64'h1000 || ic_req_valid !== 1'b1) begin
            n_fail++; $display("FAIL unaligned_addr: got %h/%b want 1000/1", ic_req_addr, ic_req_valid);
        end
        for (int k = 0; k < 10 && fb_count == 0; k++) run_cycle(0, 1'b0, '0, 1'b0);
        n_checks++; if (fb_count !== CW'(3)) begin n_fail++; $display("FAIL unaligned_count: got %0d want 3", fb_count); end
        n_checks++; if (fb_pc !== 64'h1005) begin n_fail++; $display("FAIL unaligned_pc: got %h want 1005", fb_pc); end
        n_checks++; if (fb_bytes[7:0] !== mem_byte(64'h1005)) begin
            n_fail++; $display("FAIL unaligned_byte0: got %h want %h", fb_bytes[7:0], mem_byte(64'h1005));
        end
    endtask

    task automatic test_consume_append();
        bit done = 1'b0;
        lat_min = 1; lat_max = 1; ready_pct = 100;
        do_reset(64'h1000);
        for (int k = 0; k < 40 && !done; k++) begin
            if (ic_pend && ic_delay == 0 && m_q.size() == 24) begin
                run_cycle(3, 1'b0, '0, 1'b0);
                done = 1'b1;
            end else begin
                run_cycle(0, 1'b0, '0, 1'b0);
            end
        end
        n_checks++; if (!done) begin n_fail++; $display("FAIL overlap_timeout: no response seen at count 24"); end
        n_checks++; if (fb_count !== CW'(29)) begin n_fail++; $display("FAIL overlap_count: got %0d want 29", fb_count); end
        n_checks++; if (fb_pc !== 64'h1003) begin n_fail++; $display("FAIL overlap_pc: got %h want 1003", fb_pc); end
        n_checks++; if ((fb_bytes & win_mask()) !== win_exp()) begin
            n_fail++; $display("FAIL overlap_bytes: got %h want %h", fb_bytes & win_mask(), win_exp());
        end
    endtask

    task automatic test_redirect_wait();
        lat_min = 3; lat_max = 3; ready_pct = 100;
        do_reset(64'h1000);
        for (int k = 0; k < 10 && !m_out; k++) run_cycle(0, 1'b0, '0, 1'b0);
        run_cycle(0, 1'b1, 64'h2002, 1'b0);
        n_checks++; if (fb_count !== '0 || fb_pc !== 64'h2002) begin
            n_fail++; $display("FAIL redir_flush: got %0d/%h want 0/2002", fb_count, fb_pc);
        end
        n_checks++; if (dut.state !== FB_DROP) begin n_fail++; $display("FAIL redir_state: got %0d want %0d", dut.state, FB_DROP); end
        for (int k = 0; k < 10 && !ic_req_valid; k++) run_cycle(0, 1'b0, '0, 1'b0);
        n_checks++; if (ic_req_valid !== 1'b1 || ic_req_addr !== 64'h2000) begin
            n_fail++; $display("FAIL redir_addr: got %h/%b want 2000/1", ic_req_addr, ic_req_valid);
        end
        n_checks++; if (fb_count !== '0) begin n_fail++; $display("FAIL redir_drop: got %0d want 0", fb_count); end
        for (int k = 0; k < 10 && fb_count == 0; k++) run_cycle(0, 1'b0, '0, 1'b0);
        n_checks++; if (fb_count !== CW'(6) || fb_pc !== 64'h2002) begin
            n_fail++; $display("FAIL redir_refill: got %0d/%h want 6/2002", fb_count, fb_pc);
        end
        n_checks++; if (fb_bytes[7:0] !== mem_byte(64'h2002)) begin
            n_fail++; $display("FAIL redir_byte0: got %h want %h", fb_bytes[7:0], mem_byte(64'h2002));
        end
    endtask

    task automatic test_wrap_stream();
        int pos = 0;
        int cons;
        logic [8*WIN_BYTES-1:0] got_s;
        logic [8*WIN_BYTES-1:0] exp_s;
        lat_min = 1; lat_max = 2; ready_pct = 70;
        do_reset(64'h1000);
        for (int k = 0; k < 2000 && pos < 320; k++) begin
            cons = (m_q.size() < 5) ? m_q.size() : 5;
            if (cons > 0) begin
                got_s = '0; exp_s = '0;
                for (int i = 0; i < cons; i++) begin
                    got_s[8*i +: 8] = fb_bytes[8*i +: 8];
                    exp_s[8*i +: 8] = mem_byte(64'h1000 + 64'(pos + i));
                end
                n_checks++; if (got_s !== exp_s) begin
                    n_fail++; $display("FAIL stream at byte %0d: got %h want %h", pos, got_s, exp_s);
                end
                pos += cons;
            end
            run_cycle(cons, 1'b0, '0, 1'b0);
            n_checks++; if (fb_count !== CW'(m_q.size())) begin
                n_fail++; $display("FAIL stream_count cycle %0d: got %0d want %0d", cyc, fb_count, m_q.size());
            end
        end
        n_checks++; if (pos < 320) begin n_fail++; $display("FAIL stream_timeout: got %0d bytes want 320", pos); end
    endtask

    task automatic test_reset_mid();
        lat_min = 3; lat_max = 3; ready_pct = 100;
        do_reset(64'h1000);
        for (int k = 0; k < 40 && !(m_out && m_q.size() >= 8); k++) run_cycle(0, 1'b0, '0, 1'b0);
        entry = 64'h3000;
        run_cycle(0, 1'b0, '0, 1'b1);
        n_checks++; if (fb_count !== '0 || fb_pc !== 64'h3000 || ic_req_valid !== 1'b0) begin
            n_fail++; $display("FAIL midreset_state: got %0d/%h/%b want 0/3000/0", fb_count, fb_pc, ic_req_valid);
        end
        for (int k = 0; k < 5 && !ic_req_valid; k++) run_cycle(0, 1'b0, '0, 1'b0);
        n_checks++; if (ic_req_valid !== 1'b1 || ic_req_addr !== 64'h3000) begin
            n_fail++; $display("FAIL midreset_addr: got %h/%b want 3000/1", ic_req_addr, ic_req_valid);
        end
        for (int k = 0; k < 10 && fb_count == 0; k++) run_cycle(0, 1'b0, '0, 1'b0);
        n_checks++; if (fb_count !== CW'(8) || fb_bytes[7:0] !== mem_byte(64'h3000)) begin
            n_fail++; $display("FAIL midreset_refill: got %0d/%h want 8/%h", fb_count, fb_bytes[7:0], mem_byte(64'h3000));
        end
    endtask

    task automatic test_random();
        int          cons;
        int          lim;
        bit          rst;
        bit          redir;
        logic [63:0] rpc;
        lat_min = 1; lat_max = 3; ready_pct = 60;
        do_reset({$urandom, $urandom});
        for (int k = 0; k < 1500; k++) begin
            rst   = ($urandom_range(299, 0) == 0);
            redir = !rst && ($urandom_range(15, 0) == 0);
            rpc   = ($urandom_range(3, 0) == 0) ? 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(15, 0))
                                                : {32'h0, $urandom};
            lim   = (m_q.size() < int'(WIN_BYTES)) ? m_q.size() : int'(WIN_BYTES);
            cons  = rst ? 0 : int'($urandom_range(lim, 0));
            if (rst) entry = {$urandom, $urandom};
            run_cycle(cons, redir, rpc, rst);
            n_checks++; if (fb_count !== CW'(m_q.size())) begin
                n_fail++; $display("FAIL rand_count cycle %0d: got %0d want %0d", cyc, fb_count, m_q.size());
            end
            n_checks++; if (fb_pc !== m_pc) begin
                n_fail++; $display("FAIL rand_pc cycle %0d: got %h want %h", cyc, fb_pc, m_pc);
            end
            n_checks++; if (ic_req_valid !== m_valid) begin
                n_fail++; $display("FAIL rand_valid cycle %0d: got %b want %b", cyc, ic_req_valid, m_valid);
            end
            if (m_valid) begin
                n_checks++; if (ic_req_addr !== m_fetch) begin
                    n_fail++; $display("FAIL rand_addr cycle %0d: got %h want %h", cyc, ic_req_addr, m_fetch);
                end
            end
            n_checks++; if ((fb_bytes & win_mask()) !== win_exp()) begin
                n_fail++; $display("FAIL rand_bytes cycle %0d: got %h want %h", cyc, fb_bytes & win_mask(), win_exp());
            end
        end
    endtask

    initial begin
        reset = 1'b1; entry = 64'h1000; redirect = 1'b0; redirect_pc = '0;
        ic_req_ready = 1'b0; ic_resp_valid = 1'b0; ic_resp_data = '0; consume = '0;
        @(negedge clk);
        test_reset();
        test_fill_stall();
        test_unaligned_entry();
        test_consume_append();
        test_redirect_wait();
        test_wrap_stream();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/mod_fetch_buffer.md
MOD_FETCH_BUFFER -- requirements
Module: mod_fetch_buffer

Interface
REQ-001 Parameter: BUF_BYTES, 32, byte capacity of the fetch queue, a multiple of 8 and at least 16.
REQ-002 Parameter: WIN_BYTES, 16, width of the byte window presented to decode.
REQ-003 clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 entry  in  64  first fetch PC after reset.
REQ-006 redirect  in  1  flush the queue and restart fetch at redirect_pc.
REQ-007 redirect_pc  in  64  new fetch PC, valid while redirect=1.
REQ-008 ic_req_valid  out  1  icache request strobe.
REQ-009 ic_req_addr  out  64  8-byte-aligned fetch address.
REQ-010 ic_req_ready  in  1  icache accepts the request when high together with ic_req_valid.
REQ-011 ic_resp_valid  in  1  one-cycle response strobe.
REQ-012 ic_resp_data  in  64  8 instruction bytes, little-endian, byte 0 at the lowest address.
REQ-013 fb_bytes  out  8*WIN_BYTES  oldest queued bytes, byte 0 in bits [7:0].
REQ-014 fb_count  out  $clog2(BUF_BYTES)+1  number of valid bytes in the queue.
REQ-015 fb_pc  out  64  PC of fb_bytes byte 0.
REQ-016 consume  in  5  bytes retired by decode this cycle, 0..WIN_BYTES.

Function
REQ-017 FSM states: REQ (ic_req_valid=1), WAIT (one request outstanding), DROP (a stale response is outstanding), STALL (the queue cannot accept 8 more bytes).
REQ-018 At most one icache request is outstanding at any time.
REQ-019 REQ->WAIT on a request handshake; ic_req_addr holds steady while ic_req_valid=1 and ready=0.
REQ-020 WAIT->REQ on ic_resp_valid when free space after the append is at least 8; otherwise WAIT->STALL.
REQ-021 On each response, fetch_addr advances by 8.
REQ-022 STALL->REQ in the first cycle in which free space is at least 8, consume included.
REQ-023 Append rule: the first response after a reset or redirect discards the low start_pc[2:0] bytes; every later response appends all 8 bytes.
REQ-024 fb_count_next = fb_count - consume + appended bytes; consume and append in the same cycle are both honoured.
REQ-025 fb_pc advances by consume modulo 2^64.
REQ-026 consume > fb_count is illegal and is flagged by an assertion; the RTL behaviour in that case is undefined.
REQ-027 fb_bytes lanes at index fb_count and above are don't-care; the bench masks them.
REQ-028 Queue storage is circular with head/tail pointers wrapping modulo BUF_BYTES; no data moves on wrap.
REQ-029 Latency: bytes from a response are visible on fb_bytes/fb_count in the cycle after ic_resp_valid.
REQ-030 Redirect effects in the next cycle: fb_count=0, fb_pc=redirect_pc, fetch_addr={redirect_pc[63:3],3'b0}, start offset=redirect_pc[2:0].
REQ-031 Redirect with a request outstanding (WAIT): go to DROP and discard the next response; DROP->REQ on that response.
REQ-032 Redirect with no request outstanding: go directly to REQ.
REQ-033 Redirect in the same cycle as ic_resp_valid discards that response; the state goes to REQ.
REQ-034 Redirect has priority over consume and append in the same cycle.
REQ-035 A second redirect during DROP updates the PC and remains in DROP.
REQ-036 Redirect in REQ before a handshake changes ic_req_addr the next cycle.
REQ-037 Redirect in the same cycle as a REQ handshake counts that request as outstanding, and the state goes to DROP.

Reset
REQ-038 While reset=1: state=REQ, fb_count=0, head=tail=0, fb_pc=entry, fetch_addr={entry[63:3],3'b0}, start offset=entry[2:0], ic_req_valid=0.
REQ-039 The first ic_req_valid=1 occurs in the cycle after reset deasserts.
REQ-040 Reset asserted mid-operation abandons any outstanding request.
REQ-041 A response arriving in the cycle reset deasserts is ignored.
REQ-042 The icache is reset by the same reset, so no stale response follows.

Structure
REQ-043 The shared package holds the FSM state enum (FB_REQ, FB_WAIT, FB_DROP, FB_STALL) and the constant FETCH_WORD_BYTES=8.
REQ-044 The byte queue is one sub-module, fb_byte_ring: a circular byte store with 8-byte write and WIN_BYTES read.
REQ-045 The FSM and PC logic live in mod_fetch_buffer.

Verification
REQ-046 entry=0x1000, icache responds 1 cycle after each handshake -> fb_count sequence 8,16,24,32 with consume=0; state STALL at 32; no 5th request.
REQ-047 entry=0x1005 -> first ic_req_addr=0x1000, fb_count=3, fb_pc=0x1005, fb_bytes[7:0]=response byte 5.
REQ-048 fb_count=24 and consume=3 in the same cycle as a response -> fb_count=29, fb_pc+=3.
REQ-049 Redirect to 0x2002 while in WAIT -> the next response is dropped, the next request addr=0x2000, then fb_count=6, fb_pc=0x2002.
REQ-050 Run 40 fetches consuming 5 bytes per cycle -> the byte stream equals memory order across several head/tail wraps.
REQ-051 Assert reset mid-WAIT for 1 cycle with entry=0x3000 -> fb_count=0, fb_pc=0x3000, next request addr=0x3000.
